// File: rtl/doom_btn_conditioner.sv
// Push-button conditioner: 2-flop sync, press/release debounce, one-shot SCEN.
// Define DOOM_BTN_AUTOREPEAT_EN to get MCEN auto-repeat pulses while the button is held.
`timescale 1ns/1ps
module doom_btn_conditioner #(
  parameter int DEBOUNCE_CYC      = 1_000_000,
  parameter int REPEAT_DELAY_CYC  = 50_000_000,
  parameter int REPEAT_PERIOD_CYC = 20_000_000,
  parameter int CNT_W             = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_INI  = 3'b000,
    S_WQ   = 3'b001,
    S_SCEN = 3'b010,
    S_CCR  = 3'b011,
    S_MCEN = 3'b100,
    S_WFCR = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             pb_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef DOOM_BTN_AUTOREPEAT_EN
  // Targets are two short of the period: one cycle for CCR entry, one for MCEN_ST itself.
  localparam logic [CNT_W-1:0] DLY_TGT = CNT_W'(REPEAT_DELAY_CYC - 2);
  localparam logic [CNT_W-1:0] PER_TGT = CNT_W'(REPEAT_PERIOD_CYC - 2);
  logic             rpt_first_q, rpt_first_d;
  logic [CNT_W-1:0] rpt_tgt;
  assign rpt_tgt = rpt_first_q ? DLY_TGT : PER_TGT;
`endif

  assign pb_s    = sync2_q;
  assign state_o = state_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= S_INI;
      cnt_q       <= '0;
`ifdef DOOM_BTN_AUTOREPEAT_EN
      rpt_first_q <= 1'b1;
`endif
    end else begin
      sync1_q     <= PB;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef DOOM_BTN_AUTOREPEAT_EN
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    DPB     = 1'b0;
    SCEN    = 1'b0;
    MCEN    = 1'b0;
`ifdef DOOM_BTN_AUTOREPEAT_EN
    rpt_first_d = rpt_first_q;
`endif
    case (state_q)
      S_INI: begin
        if (pb_s) state_d = S_WQ;
      end
      S_WQ: begin
        if (!pb_s)                 state_d = S_INI;
        else if (cnt_q == DEB_LAST) state_d = S_SCEN;
        else                       cnt_d = cnt_q + CNT_W'(1);
      end
      S_SCEN: begin
        SCEN    = 1'b1;
        DPB     = 1'b1;
        state_d = S_CCR;
`ifdef DOOM_BTN_AUTOREPEAT_EN
        rpt_first_d = 1'b1;
`endif
      end
      S_CCR: begin
        DPB = 1'b1;
`ifdef DOOM_BTN_AUTOREPEAT_EN
        if (!pb_s)                 state_d = S_WFCR;
        else if (cnt_q == rpt_tgt) state_d = S_MCEN;
        else                       cnt_d = cnt_q + CNT_W'(1);
`else
        // Without repeat the counter stays idle here so it cannot wrap on a long hold.
        if (!pb_s) state_d = S_WFCR;
`endif
      end
`ifdef DOOM_BTN_AUTOREPEAT_EN
      S_MCEN: begin
        MCEN        = 1'b1;
        DPB         = 1'b1;
        state_d     = S_CCR;
        rpt_first_d = 1'b0;
      end
`endif
      S_WFCR: begin
        DPB = 1'b1;
        if (pb_s) begin
          state_d = S_CCR;
`ifdef DOOM_BTN_AUTOREPEAT_EN
          rpt_first_d = 1'b0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_INI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_INI;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

endmodule

// File: tb/tb_doom_btn_conditioner.sv
// Directed bench for doom_btn_conditioner with small debounce/repeat counts.
`timescale 1ns/1ps
module tb_doom_btn_conditioner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       PB;
  logic       DPB, SCEN, MCEN;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

`ifdef DOOM_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  // A repeat pulse lands on the release path in the 30-cycle hold, delaying DPB fall by one edge.
  localparam int REL_EDGE = AR ? 8 : 7;

  always #5 Clk = ~Clk;

  doom_btn_conditioner #(
    .DEBOUNCE_CYC(4), .REPEAT_DELAY_CYC(10), .REPEAT_PERIOD_CYC(5), .CNT_W(26)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PB(PB),
    .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic release_to_ini(input string tag);
    bit ok;
    ok = 1'b0;
    PB = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (state_o == 3'b000) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int scen_cnt;
    bit exp_m;

    // 1: reset
    Reset = 1'b1;
    PB    = 1'b0;
    #2;
    chk("t1_state_in_rst", 32'(state_o), 32'd0);
    chk("t1_outs_in_rst", 32'({DPB, SCEN, MCEN}), 32'd0);
    #10;
    chk("t1_state_in_rst2", 32'(state_o), 32'd0);
    #8 Reset = 1'b0;
    #6;
    chk("t1_state_after", 32'(state_o), 32'd0);
    chk("t1_outs_after", 32'({DPB, SCEN, MCEN}), 32'd0);

    // 2: clean press and release
    scen_cnt = 0;
    PB = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (SCEN) scen_cnt++;
      chk("t2_scen", 32'(SCEN), 32'(k == 7));
      chk("t2_dpb", 32'(DPB), 32'(k >= 7));
      if (k == 3) chk("t2_state_wq", 32'(state_o), 32'd1);
      if (k == 8) chk("t2_state_ccr", 32'(state_o), 32'd3);
    end
    PB = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (SCEN) scen_cnt++;
      chk("t2_rel_dpb", 32'(DPB), 32'(j < REL_EDGE));
    end
    chk("t2_state_end", 32'(state_o), 32'd0);
    chk("t2_scen_total", 32'(scen_cnt), 32'd1);

    // 3: bounce never long enough
    for (int i = 0; i < 30; i++) begin
      PB = (i % 3) != 2;
      step();
      chk("t3_scen", 32'(SCEN), 32'd0);
      chk("t3_dpb", 32'(DPB), 32'd0);
      chk("t3_state", 32'(state_o inside {3'b000, 3'b001}), 32'd1);
    end
    PB = 1'b0;
    step(); step(); step();
    chk("t3_state_end", 32'(state_o), 32'd0);

    // 4: release bounce mid-hold
    PB = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t4_scen_press", 32'(SCEN), 32'(k == 7));
    end
    PB = 1'b0;
    step(); step();
    PB = 1'b1;
    for (int e = 12; e <= 20; e++) begin
      step();
      chk("t4_dpb", 32'(DPB), 32'd1);
      chk("t4_scen", 32'(SCEN), 32'd0);
      if (e <= 13) chk("t4_state_wfcr", 32'(state_o), 32'd5);
      if (e == 14) chk("t4_state_ccr", 32'(state_o), 32'd3);
    end
    release_to_ini("t4_back_ini");

    // 5: long hold, auto-repeat
    PB = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t5_scen_press", 32'(SCEN), 32'(k == 7));
    end
    for (int m = 1; m <= 40; m++) begin
      step();
      exp_m = AR && (m >= 10) && ((m - 10) % 5 == 0);
      chk("t5_mcen", 32'(MCEN), 32'(exp_m));
      chk("t5_scen", 32'(SCEN), 32'd0);
      chk("t5_dpb", 32'(DPB), 32'd1);
    end
    release_to_ini("t5_back_ini");

    // 6: async reset mid-debounce
    PB = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    chk("t6_state_wq", 32'(state_o), 32'd1);
    #3 Reset = 1'b1;
    #1;
    chk("t6_state_async", 32'(state_o), 32'd0);
    chk("t6_outs_async", 32'({DPB, SCEN, MCEN}), 32'd0);
    @(posedge Clk);
    #1;
    chk("t6_state_held", 32'(state_o), 32'd0);
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_scen", 32'(SCEN), 32'(k == 7));
      if (k == 3) chk("t6_state_wq2", 32'(state_o), 32'd1);
    end
    release_to_ini("t6_back_ini");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
